// File: rtl/iomem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_arbiter_if
//  Brief    : picosoc iomem bus bundle (request fields plus ready/rdata return)
//  Revision : 1.0 - initial release
// ============================================================================
interface iomem_arbiter_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
   modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/iomem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_arbiter
//  Brief    : two-master round-robin arbiter for the picosoc iomem bus with
//             slave timeout and sticky error flag
//  Revision : 1.0 - initial release
// ============================================================================
module iomem_arbiter #(
   parameter int unsigned TIMEOUT       = 256,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
   input  logic            clk,
   input  logic            resetn,
   iomem_arbiter_if.slave  m0,
   iomem_arbiter_if.slave  m1,
   iomem_arbiter_if.master s,
   output logic            err,
   output logic            err_src,
   input  logic            err_clr
);

   localparam int unsigned            c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0]     c_CNT_LAST = (TIMEOUT == 0) ? '0 : c_CNT_W'(TIMEOUT - 1);
   localparam logic [1:0]             c_IDLE     = 2'd0;
   localparam logic [1:0]             c_BUSY     = 2'd1;
   localparam logic [1:0]             c_DONE     = 2'd2;

   logic [1:0]         r_state;
   logic               r_gnt;
   logic               r_last;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_s_valid;
   logic [3:0]         r_s_wstrb;
   logic [31:0]        r_s_addr;
   logic [31:0]        r_s_wdata;
   logic               r_m0_ready;
   logic               r_m1_ready;
   logic [31:0]        r_m0_rdata;
   logic [31:0]        r_m1_rdata;
   logic               r_err;
   logic               r_err_src;

   logic               w_any;
   logic               w_gnt;
   logic               w_tmo;
   logic               w_finish;
   logic [31:0]        w_rdata;

   // On a tie the master that did not win last time gets the bus.
   assign w_any    = m0.valid | m1.valid;
   assign w_gnt    = (m0.valid & m1.valid) ? ~r_last : m1.valid;
   assign w_tmo    = (r_state == c_BUSY) && (TIMEOUT != 0) && !s.ready && (r_cnt == c_CNT_LAST);
   assign w_finish = (r_state == c_BUSY) && (s.ready || w_tmo);
   assign w_rdata  = s.ready ? s.rdata : TIMEOUT_RDATA;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= c_IDLE;
         r_gnt      <= 1'b0;
         r_last     <= 1'b1;
         r_cnt      <= '0;
         r_s_valid  <= 1'b0;
         r_s_wstrb  <= 4'd0;
         r_s_addr   <= 32'd0;
         r_s_wdata  <= 32'd0;
         r_m0_ready <= 1'b0;
         r_m1_ready <= 1'b0;
         r_m0_rdata <= 32'd0;
         r_m1_rdata <= 32'd0;
         r_err      <= 1'b0;
         r_err_src  <= 1'b0;
      end else begin
         r_m0_ready <= 1'b0;
         r_m1_ready <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_any) begin
                  r_gnt     <= w_gnt;
                  r_s_valid <= 1'b1;
                  r_s_wstrb <= w_gnt ? m1.wstrb : m0.wstrb;
                  r_s_addr  <= w_gnt ? m1.addr  : m0.addr;
                  r_s_wdata <= w_gnt ? m1.wdata : m0.wdata;
                  r_cnt     <= '0;
                  r_state   <= c_BUSY;
               end
            end
            c_BUSY: begin
               if (w_finish) begin
                  if (r_gnt) begin
                     r_m1_ready <= 1'b1;
                     r_m1_rdata <= w_rdata;
                  end else begin
                     r_m0_ready <= 1'b1;
                     r_m0_rdata <= w_rdata;
                  end
                  r_s_valid <= 1'b0;
                  r_last    <= r_gnt;
                  r_state   <= c_DONE;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            // Valid is deliberately not sampled here so a held request is not re-granted.
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase

         if (w_tmo) begin
            r_err     <= 1'b1;
            r_err_src <= r_gnt;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign s.valid  = r_s_valid;
   assign s.wstrb  = r_s_wstrb;
   assign s.addr   = r_s_addr;
   assign s.wdata  = r_s_wdata;
   assign m0.ready = r_m0_ready;
   assign m1.ready = r_m1_ready;
   assign m0.rdata = r_m0_rdata;
   assign m1.rdata = r_m1_rdata;
   assign err      = r_err;
   assign err_src  = r_err_src;

endmodule
`default_nettype wire

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-master round-robin arbiter for the picosoc external iomem bus. Master 0 is the picosoc core iomem port and master 1 is an auxiliary requester (DMA or debug). Both share the single slave-side iomem bus that drives the output pads. The block sequences one transaction at a time, holds the grant until the slave completes, and recovers from unresponsive slaves with a bus timeout and a sticky error flag.

## Interface
Parameters:
- TIMEOUT, 256: maximum BUSY cycles before forced completion; 0 disables the timeout.
- TIMEOUT_RDATA, 32'hFFFF_FFFF: read data returned on a timed-out transaction.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- m0_valid / m1_valid  in  1  master request, held until that master's ready.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_wstrb / m1_wstrb  in  4  write strobes; 0 = read.
- m0_addr / m1_addr  in  32  address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready = 1.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_wstrb  out  4, s_addr  out  32, s_wdata  out  32  registered slave request fields.
- s_rdata  in  32  slave read data, sampled with s_ready.
- err  out  1  sticky timeout flag.
- err_src  out  1  master ID of the most recent timeout.
- err_clr  in  1  synchronous clear of err.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any m*_valid is 1, grant one master, latch its wstrb/addr/wdata into the s_* registers, set s_valid = 1, clear the timeout counter, and go to BUSY.
- Arbitration priority: the master that is not last_grant wins. If only one master requests, it wins. last_grant resets to 1, so master 0 wins the first tie.
- BUSY, s_ready = 1:
  - Register s_rdata into the granted master's rdata.
  - Pulse the granted master's ready.
  - Drop s_valid, set last_grant = granted ID, go to DONE.
- BUSY, s_ready = 0 and TIMEOUT != 0 and counter == TIMEOUT-1:
  - Complete the transaction the same way, but with rdata = TIMEOUT_RDATA.
  - Set err = 1 and err_src = granted ID. Go to DONE.
- BUSY, otherwise: increment the counter. s_* fields stay frozen.
- DONE: lasts exactly one cycle; ready is high during it, then go to IDLE. Masters drop or re-issue valid in this cycle. Because the arbiter does not sample valid in DONE, a request is never granted twice.
- The non-granted master's ready stays 0. Its rdata holds its last value.
- Master request fields are ignored outside IDLE. A master changing its fields mid-transaction does not affect s_*.
- err_clr and a new timeout in the same cycle: set wins.
- The counter saturates and cannot wrap while in BUSY.

## Timing
- Reset values: s_valid = 0; s_wstrb/s_addr/s_wdata = 0; m*_ready = 0; m*_rdata = 0; err = 0; err_src = 0; state IDLE; last_grant = 1.
- Request to slave: m_valid sampled at edge E gives s_valid = 1 after E (1-cycle latency).
- Slave to master: s_ready sampled at edge F gives m_ready = 1 for exactly the cycle after F.
- Minimum transaction length is 3 cycles: IDLE grant, BUSY with s_ready already high, DONE. Back-to-back throughput is therefore one transaction per 3 cycles.
- Timeout: s_valid stays high for exactly TIMEOUT cycles, then ready asserts.
- Asynchronous reset mid-transaction: all outputs return to their reset values immediately. The in-flight transaction is abandoned and no ready is issued.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single read: m0 reads addr 0x0300_0000, slave answers 0x1234_5678 after 2 cycles. Required: s_valid high for 3 cycles, m0_ready pulses once with m0_rdata = 0x1234_5678, m1_ready stays 0.
- Simultaneous requests: m0 and m1 both valid out of reset. Required grant order is m0 then m1. With both held continuously, grants alternate m0, m1, m0, m1 over 4 transactions.
- Write pass-through: m1 writes wstrb 4'b0011, addr 0x0300_0010, wdata 0xCAFE_F00D. Required: s_* fields match exactly and stay stable for the whole BUSY period even if m1_addr changes.
- Timeout: TIMEOUT = 8, s_ready tied low, m1 reads. Required: ready pulses 9 cycles after grant, m1_rdata = 0xFFFF_FFFF, err = 1, err_src = 1. Then assert err_clr; err must drop on the next edge.
- Reset mid-BUSY: deassert resetn during a stalled transaction. Required: s_valid = 0 and ready = 0 immediately. After release, a fresh m0 request completes normally.
- Stale-valid check: a master holds valid for one extra cycle after ready (through DONE). Required: no duplicate s_valid transaction is issued for it.
